uart_tx_tick: RTL and testbench

Serial transmitter that consumes the one-clk-wide enable pulse produced by the team's prescaler as its bit-rate tick. Accepts a parallel word over a valid/ready handshake, then serialises it LSB-first as start bit, data bits, optional parity and stop bit(s). Each bit lasts exactly one tick period. Sits directly downstream of the prescaler and drives the board TX pin.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tx_tick.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_tick.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
//   tx_state_e   : transmitter FSM states
//   PAR_*        : parity mode encodings used by the PARITY parameter
//   MAX_DATA_W   : widest supported data word
//   calc_parity  : parity bit for a zero-extended data word
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    localparam int PAR_NONE   = 0;
    localparam int PAR_ODD    = 1;
    localparam int PAR_EVEN   = 2;
    localparam int MAX_DATA_W = 9;

    // Even parity is the XOR of the data bits, odd parity its inverse.
    // The caller zero-extends the word, so the unused upper bits do not
    // disturb the result.
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                         input int                    mode);
        logic x;
        logic result;
        x = ^data;
        case (mode)
            PAR_ODD:  result = ~x;
            PAR_EVEN: result = x;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter driven by an external bit-rate tick.
// A word accepted over valid/ready is sent LSB-first as
// start bit, DATA_W data bits, optional parity bit and STOP_BITS stop bits.
// Every bit lasts exactly one tick period.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   tick     one-cycle bit-rate enable from the prescaler (period >= 2 clk)
//   data_i   word to transmit
//   valid_i  data_i is valid
//   ready_o  transmitter idle, a word can be accepted
//   tx_o     serial line, idle high, registered
//   busy_o   frame in progress
//   done_o   one-cycle pulse when the last stop bit period ends
module uart_tx_tick
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // Elaboration-time parameter range checks.
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_tick: DATA_W must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_tick: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_tick: STOP_BITS must be 1 or 2");
    end

    tx_state_e               state_r;
    tx_state_e               state_s;
    logic [DATA_W-1:0]       shift_r;
    logic [DATA_W-1:0]       shift_s;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [CNT_W-1:0]        bit_cnt_s;
    logic [1:0]              stop_cnt_r;
    logic [1:0]              stop_cnt_s;
    logic                    par_r;
    logic                    par_s;
    logic                    tx_r;
    logic                    tx_s;
    logic                    done_r;
    logic                    done_s;
    logic [MAX_DATA_W-1:0]   data_ext_s;

    assign data_ext_s = MAX_DATA_W'(data_i);

    // Next-state and next-output logic for the transmitter FSM.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        stop_cnt_s = stop_cnt_r;
        par_s      = par_r;
        tx_s       = tx_r;
        done_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tx_s = 1'b1;
                // A tick in the accept cycle is deliberately ignored; ARM
                // waits for the next one so the start bit is a full period.
                if (valid_i) begin
                    shift_s    = data_i;
                    par_s      = calc_parity(data_ext_s, PARITY);
                    bit_cnt_s  = '0;
                    stop_cnt_s = 2'd0;
                    state_s    = ST_ARM;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ARM: begin
                if (tick) begin
                    tx_s    = 1'b0;
                    state_s = ST_START;
                end else begin
                    state_s = ST_ARM;
                end
            end

            ST_START: begin
                if (tick) begin
                    tx_s      = shift_r[0];
                    shift_s   = {1'b0, shift_r[DATA_W-1:1]};
                    bit_cnt_s = CNT_W'(1);
                    state_s   = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_r < CNT_W'(DATA_W)) begin
                        tx_s      = shift_r[0];
                        shift_s   = {1'b0, shift_r[DATA_W-1:1]};
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    end else if (PARITY != PAR_NONE) begin
                        tx_s    = par_r;
                        state_s = ST_PARITY;
                    end else begin
                        tx_s       = 1'b1;
                        stop_cnt_s = 2'd1;
                        state_s    = ST_STOP;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    tx_s       = 1'b1;
                    stop_cnt_s = 2'd1;
                    state_s    = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end

            ST_STOP: begin
                if (tick) begin
                    // stop_cnt counts stop-bit periods already started; the
                    // tick that ends the last one returns to IDLE.
                    if (stop_cnt_r < 2'(STOP_BITS)) begin
                        stop_cnt_s = stop_cnt_r + 2'd1;
                    end else begin
                        tx_s    = 1'b1;
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end

            default: begin
                tx_s    = 1'b1;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 2'd0;
            par_r      <= 1'b0;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            stop_cnt_r <= stop_cnt_s;
            par_r      <= par_s;
            tx_r       <= tx_s;
            done_r     <= done_s;
        end
    end

    assign ready_o = (state_r == ST_IDLE);
    assign busy_o  = ~ready_o;
    assign tx_o    = tx_r;
    assign done_o  = done_r;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Self-checking bench for uart_tx_tick: four instances with different
// parameter sets share clock, reset and tick; a frame-level reference model
// predicts every output each cycle, and directed steps check the waveform
// details of single frames.
module tb_uart_tx_tick;

    localparam int NK = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    int              ratio = 4;
    int              phase = 0;
    logic            tick;
    logic [8:0]      data_v [NK];
    logic [NK-1:0]   valid_v;
    logic [NK-1:0]   tx_w;
    logic [NK-1:0]   ready_w;
    logic [NK-1:0]   busy_w;
    logic [NK-1:0]   done_w;

    int checks = 0;
    int fails  = 0;
    int done_cnt [NK];

    // reference model state: frame as a bit list plus index of the bit on the line
    logic        m_busy [NK];
    logic [15:0] m_bits [NK];
    int          m_idx  [NK];
    logic        m_tx   [NK];
    logic        m_done [NK];

    always #5 clk = ~clk;

    // prescaler stand-in: one-cycle tick every 'ratio' clocks
    always @(posedge clk) phase <= (phase >= ratio - 1) ? 0 : phase + 1;
    assign tick = (phase == ratio - 1);

    uart_tx_tick #(.DATA_W(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .data_i(data_v[0][7:0]),
        .valid_i(valid_v[0]), .ready_o(ready_w[0]), .tx_o(tx_w[0]),
        .busy_o(busy_w[0]), .done_o(done_w[0]));

    uart_tx_tick #(.DATA_W(8), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .data_i(data_v[1][7:0]),
        .valid_i(valid_v[1]), .ready_o(ready_w[1]), .tx_o(tx_w[1]),
        .busy_o(busy_w[1]), .done_o(done_w[1]));

    uart_tx_tick #(.DATA_W(8), .PARITY(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .tick(tick), .data_i(data_v[2][7:0]),
        .valid_i(valid_v[2]), .ready_o(ready_w[2]), .tx_o(tx_w[2]),
        .busy_o(busy_w[2]), .done_o(done_w[2]));

    uart_tx_tick #(.DATA_W(5), .PARITY(1), .STOP_BITS(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .tick(tick), .data_i(data_v[3][4:0]),
        .valid_i(valid_v[3]), .ready_o(ready_w[3]), .tx_o(tx_w[3]),
        .busy_o(busy_w[3]), .done_o(done_w[3]));

    function automatic int cfg_w(input int k);
        return (k == 3) ? 5 : 8;
    endfunction

    function automatic int cfg_p(input int k);
        case (k)
            1:       return 2;
            2, 3:    return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_s(input int k);
        return (k == 1 || k == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int k);
        return 1 + cfg_w(k) + ((cfg_p(k) != 0) ? 1 : 0) + cfg_s(k);
    endfunction

    // line bits of a whole frame, index 0 = start bit; unused tail stays 1
    function automatic logic [15:0] frame_bits(input int k, input logic [8:0] d);
        logic [15:0] b;
        int          w;
        int          ones;
        b    = 16'hFFFF;
        b[0] = 1'b0;
        w    = cfg_w(k);
        ones = 0;
        for (int i = 0; i < w; i++) begin
            b[1 + i] = d[i];
            ones += int'(d[i]);
        end
        if (cfg_p(k) == 2) b[1 + w] = (ones % 2 == 1);
        else if (cfg_p(k) == 1) b[1 + w] = (ones % 2 == 0);
        return b;
    endfunction

    // reference model: accept when idle and valid, then one frame bit per tick
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NK; k++) begin
                m_busy[k] <= 1'b0;
                m_bits[k] <= 16'hFFFF;
                m_idx[k]  <= 0;
                m_tx[k]   <= 1'b1;
                m_done[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                m_done[k] <= 1'b0;
                if (!m_busy[k]) begin
                    if (valid_v[k]) begin
                        m_busy[k] <= 1'b1;
                        m_bits[k] <= frame_bits(k, data_v[k]);
                        m_idx[k]  <= -1;
                    end
                end else if (tick) begin
                    if (m_idx[k] + 1 == frame_len(k)) begin
                        m_busy[k] <= 1'b0;
                        m_tx[k]   <= 1'b1;
                        m_done[k] <= 1'b1;
                    end else begin
                        m_idx[k] <= m_idx[k] + 1;
                        m_tx[k]  <= m_bits[k][m_idx[k] + 1];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s[%0d] actual=%0h expected=%0h", tag, idx, act, exp);
        end
    endtask

    // advance to the next falling edge and compare every instance to the model
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            chk("sb_tx", k, 32'(tx_w[k]), 32'(m_tx[k]));
            chk("sb_ready", k, 32'(ready_w[k]), 32'(!m_busy[k]));
            chk("sb_busy", k, 32'(busy_w[k]), 32'(m_busy[k]));
            chk("sb_done", k, 32'(done_w[k]), 32'(m_done[k]));
            if (done_w[k] === 1'b1) done_cnt[k]++;
        end
    endtask

    // advance until the coming rising edge carries a tick
    task automatic wait_tick();
        int g;
        g = 0;
        while (!tick && g < 50) begin
            step();
            g++;
        end
        chk("tick_seen", 0, 32'(tick), 32'(1));
    endtask

    task automatic send(input int k, input logic [8:0] d);
        int g;
        g = 0;
        while (!ready_w[k] && g < 400) begin
            step();
            g++;
        end
        chk("send_ready", k, 32'(ready_w[k]), 32'(1));
        valid_v[k] = 1'b1;
        data_v[k]  = d;
        step();
        valid_v[k] = 1'b0;
        data_v[k]  = 9'($urandom);
    endtask

    // sample line bits first..n-1 just after the ticks that launch them
    task automatic expect_bits(input int k, input logic [15:0] bits,
                               input int first, input int n, input bit want_done);
        for (int i = first; i < n; i++) begin
            wait_tick();
            step();
            chk("frame_bit", k * 100 + i, 32'(tx_w[k]), 32'(bits[i]));
            chk("frame_ready_low", k, 32'(ready_w[k]), 32'(0));
        end
        if (want_done) begin
            wait_tick();
            step();
            chk("frame_done", k, 32'(done_w[k]), 32'(1));
            chk("frame_ready_back", k, 32'(ready_w[k]), 32'(1));
        end
    endtask

    initial begin
        int          g;
        int          n;
        int          hi;
        int          dc;
        int          low;
        int          k;
        logic [8:0]  d;
        logic [15:0] exp_bits;

        rst_n   = 1'b0;
        valid_v = '0;
        for (int i = 0; i < NK; i++) begin
            data_v[i]   = 9'd0;
            done_cnt[i] = 0;
        end
        repeat (3) step();
        for (int i = 0; i < NK; i++) begin
            chk("rst_tx", i, 32'(tx_w[i]), 32'(1));
            chk("rst_ready", i, 32'(ready_w[i]), 32'(1));
            chk("rst_busy", i, 32'(busy_w[i]), 32'(0));
            chk("rst_done", i, 32'(done_w[i]), 32'(0));
        end
        rst_n = 1'b1;

        // idle line with ticks running and no valid
        low = 0;
        repeat (50) begin
            step();
            if (tx_w[0] !== 1'b1) low++;
        end
        chk("idle_tx_low_cycles", 0, 32'(low), 32'(0));
        chk("idle_done_cnt", 0, 32'(done_cnt[0]), 32'(0));

        // 0x55, no parity, one stop bit: 0,1,0,1,0,1,0,1,0,1
        dc = done_cnt[0];
        send(0, 9'h055);
        exp_bits = 16'h02AA;
        expect_bits(0, exp_bits, 0, 10, 1'b1);
        repeat (2) step();
        chk("x55_done_once", 0, 32'(done_cnt[0] - dc), 32'(1));

        // 0xA3 on the even (2 stop) and odd instances in lockstep
        g = 0;
        while (!(ready_w[1] && ready_w[2]) && g < 400) begin
            step();
            g++;
        end
        chk("a3_ready", 1, 32'(ready_w[1] & ready_w[2]), 32'(1));
        valid_v[1] = 1'b1; data_v[1] = 9'h0A3;
        valid_v[2] = 1'b1; data_v[2] = 9'h0A3;
        step();
        valid_v[1] = 1'b0;
        valid_v[2] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            step();
            exp_bits = 16'h0D46;
            chk("a3_even_bit", i, 32'(tx_w[1]), 32'(exp_bits[i]));
            exp_bits = 16'h0746;
            if (i < 11) chk("a3_odd_bit", i, 32'(tx_w[2]), 32'(exp_bits[i]));
            else chk("a3_odd_done", 2, 32'(done_w[2]), 32'(1));
        end
        wait_tick();
        step();
        chk("a3_even_done", 1, 32'(done_w[1]), 32'(1));

        // back-to-back 0x0F then 0xF0 on the two-stop instance, valid held high
        g = 0;
        while (!ready_w[1] && g < 400) begin
            step();
            g++;
        end
        chk("b2b_ready0", 1, 32'(ready_w[1]), 32'(1));
        data_v[1]  = 9'h00F;
        valid_v[1] = 1'b1;
        step();
        data_v[1] = 9'h0F0;
        hi = 0;
        g  = 0;
        do begin
            step();
            g++;
            hi = tx_w[1] ? hi + 1 : 0;
        end while (!done_w[1] && g < 400);
        chk("b2b_done", 1, 32'(done_w[1]), 32'(1));
        chk("b2b_ready_rise", 1, 32'(ready_w[1]), 32'(1));
        // high samples include the done cycle itself: stop bits last 2 ticks
        chk("b2b_stop_cycles", 1, 32'(hi - 1), 32'(2 * ratio));
        step();
        chk("b2b_accept_same_cycle", 1, 32'(ready_w[1]), 32'(0));
        valid_v[1] = 1'b0;
        // after done, the start bit waits for the next tick (one period)
        n = 1;
        while (tx_w[1] && n < 100) begin
            step();
            n++;
        end
        chk("b2b_start_gap", 1, 32'(n), 32'(ratio));
        expect_bits(1, frame_bits(1, 9'h0F0), 1, frame_len(1), 1'b1);

        // accept together with a tick, then valid again while busy
        dc = done_cnt[2];
        g  = 0;
        while (!(tick && ready_w[2]) && g < 400) begin
            step();
            g++;
        end
        chk("tick_align", 2, 32'(tick & ready_w[2]), 32'(1));
        d = 9'($urandom_range(0, 255));
        valid_v[2] = 1'b1;
        data_v[2]  = d;
        step();
        data_v[2] = 9'h0FF;
        n = 0;
        do begin
            step();
            n++;
            if (n == 2) valid_v[2] = 1'b0;
        end while (tx_w[2] && n < 100);
        chk("start_after_next_tick", 2, 32'(n), 32'(ratio));
        expect_bits(2, frame_bits(2, d), 1, frame_len(2), 1'b1);
        repeat (3 * ratio) step();
        chk("busy_valid_no_frame", 2, 32'(busy_w[2]), 32'(0));
        chk("busy_valid_done_cnt", 2, 32'(done_cnt[2] - dc), 32'(1));

        // reset while the 4th data bit is on the line
        d = 9'($urandom_range(0, 255));
        send(0, d);
        expect_bits(0, frame_bits(0, d), 0, 5, 1'b0);
        dc = done_cnt[0];
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NK; i++) begin
            chk("abort_tx", i, 32'(tx_w[i]), 32'(1));
            chk("abort_ready", i, 32'(ready_w[i]), 32'(1));
            chk("abort_busy", i, 32'(busy_w[i]), 32'(0));
            chk("abort_done", i, 32'(done_w[i]), 32'(0));
        end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2 * ratio) step();
        chk("abort_no_done", 0, 32'(done_cnt[0] - dc), 32'(0));
        d = 9'($urandom_range(0, 255));
        send(0, d);
        expect_bits(0, frame_bits(0, d), 0, frame_len(0), 1'b1);

        // random words, instances and tick ratios (including the minimum of 2)
        for (int r = 0; r < 10; r++) begin
            g = 0;
            while (!(&ready_w) && g < 400) begin
                step();
                g++;
            end
            chk("rand_all_idle", r, 32'(&ready_w), 32'(1));
            ratio = (r == 0) ? 2 : int'($urandom_range(2, 6));
            step();
            k = int'($urandom_range(0, NK - 1));
            d = 9'($urandom);
            send(k, d);
            expect_bits(k, frame_bits(k, d), 0, frame_len(k), 1'b1);
        end
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
